// File: rtl/set_pkg.sv
// set_pkg: definitions shared by the set_host slice.
// Contents: FSM state enum, command mode encodings, field-slice constants for
// the central/radius words, the queued command record and a field extractor.
package set_pkg;

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StOut} state_e;

   localparam logic [1:0] MODE_A   = 2'd0;  // A only
   localparam logic [1:0] MODE_AND = 2'd1;  // A and B
   localparam logic [1:0] MODE_XOR = 2'd2;  // A xor B
   localparam logic [1:0] MODE_ILL = 2'd3;  // rejected without starting the engine

   localparam int unsigned FLD_W = 4;

   // LSB positions of each 4-bit field inside the 24-bit central word
   localparam int unsigned CEN_AX_LSB = 20;
   localparam int unsigned CEN_AY_LSB = 16;
   localparam int unsigned CEN_BX_LSB = 12;
   localparam int unsigned CEN_BY_LSB = 8;

   // LSB positions of each 4-bit field inside the 12-bit radius word
   localparam int unsigned RAD_RA_LSB = 8;
   localparam int unsigned RAD_RB_LSB = 4;

   localparam int unsigned CMD_W = 42;

   typedef struct packed {
      logic [23:0] central;
      logic [11:0] radius;
      logic [1:0]  mode;
      logic [3:0]  tag;
   } cmd_t;

   // Pull one 4-bit field out of a word (radius words are zero-extended to 24 bits)
   function automatic logic [FLD_W-1:0] fld(input logic [23:0] word, input int unsigned lsb);
      return word[lsb +: FLD_W];
   endfunction

endpackage

// File: rtl/set_host_if.sv
// set_host_if: command, engine and result buses of set_host.
// master: the set_host view (accepts commands, drives the engine, presents results).
// slave:  the environment view (command source, SET engine and result sink).
//   cmd_valid/cmd_ready, cmd_central[24], cmd_radius[12], cmd_mode[2]
//   set_en, set_central[24], set_radius[12], set_mode[2], set_busy, set_valid, set_candidate[8]
//   res_valid/res_ready, res_candidate[8], res_mode[2], res_tag[4], res_err
interface set_host_if;

   logic        cmd_valid;
   logic        cmd_ready;
   logic [23:0] cmd_central;
   logic [11:0] cmd_radius;
   logic [1:0]  cmd_mode;

   logic        set_en;
   logic [23:0] set_central;
   logic [11:0] set_radius;
   logic [1:0]  set_mode;
   logic        set_busy;
   logic        set_valid;
   logic [7:0]  set_candidate;

   logic        res_valid;
   logic        res_ready;
   logic [7:0]  res_candidate;
   logic [1:0]  res_mode;
   logic [3:0]  res_tag;
   logic        res_err;

   modport master (
      input  cmd_valid, cmd_central, cmd_radius, cmd_mode,
      output cmd_ready,
      output set_en, set_central, set_radius, set_mode,
      input  set_busy, set_valid, set_candidate,
      output res_valid, res_candidate, res_mode, res_tag, res_err,
      input  res_ready
   );

   modport slave (
      output cmd_valid, cmd_central, cmd_radius, cmd_mode,
      input  cmd_ready,
      input  set_en, set_central, set_radius, set_mode,
      output set_busy, set_valid, set_candidate,
      input  res_valid, res_candidate, res_mode, res_tag, res_err,
      output res_ready
   );

endinterface

// File: rtl/set_cmd_fifo.sv
// set_cmd_fifo: synchronous FIFO holding queued set_host commands.
// Ports: clk, rst (async, active-high), push/wdata, pop/rdata (show-ahead head),
//        full, empty. Push and pop in the same cycle are both honoured.
module set_cmd_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 42
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   output logic             full,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   // One extra pointer bit separates full from empty when the indices match
   logic [AW:0]      wptr_q, rptr_q;
   logic             do_push, do_pop;

   assign empty   = (wptr_q == rptr_q);
   assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem[rptr_q[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + 1'b1;
         if (do_pop)  rptr_q <= rptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr_q[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/set_host.sv
// set_host: queues lattice-count commands, issues them one at a time to the SET
// engine and returns each count with its echoed mode and sequence tag.
// Ports: clk, rst (async, active-high), bus (set_host_if.master: command push,
//        engine start/done, result handshake).
// Optional: define SET_HOST_TIMEOUT_EN to abort a WAIT that lasts TIMEOUT_CYC
//        cycles with an error result (TIMEOUT_CYC must fit the 8-bit counter).
module set_host
   import set_pkg::*;
#(
   parameter int unsigned CMD_DEPTH   = 4,
   parameter int unsigned TIMEOUT_CYC = 128
) (
   input logic        clk,
   input logic        rst,
   set_host_if.master bus
);

   if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("CMD_DEPTH must be a power of two and at least 2");
   end
   if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
      $error("TIMEOUT_CYC must be within 1..255");
   end

   logic             rdy_q;
   logic [3:0]       tag_q;
   state_e           state_q, state_d;
   cmd_t             job_q, job_d;
   logic [7:0]       res_cand_q, res_cand_d;
   logic [1:0]       res_mode_q, res_mode_d;
   logic [3:0]       res_tag_q, res_tag_d;
   logic             res_err_q, res_err_d;

   logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [CMD_W-1:0] fifo_wdata, fifo_rdata;
   cmd_t             head;
   logic             wait_to;

   set_cmd_fifo #(
      .DEPTH (CMD_DEPTH),
      .WIDTH (CMD_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .wdata (fifo_wdata),
      .full  (fifo_full),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .empty (fifo_empty)
   );

   // rdy_q holds cmd_ready low through reset and for the first clock after it
   assign bus.cmd_ready = rdy_q & ~fifo_full;
   assign fifo_push     = bus.cmd_valid & bus.cmd_ready;
   assign fifo_wdata    = {bus.cmd_central, bus.cmd_radius, bus.cmd_mode, tag_q};
   assign head          = cmd_t'(fifo_rdata);

`ifdef SET_HOST_TIMEOUT_EN
   logic [7:0] wait_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                    wait_cnt_q <= 8'd0;
      else if (state_q == StWait) wait_cnt_q <= wait_cnt_q + 8'd1;
      else                        wait_cnt_q <= 8'd0;
   end

   // Fires in the last of TIMEOUT_CYC consecutive WAIT cycles
   assign wait_to = (state_q == StWait) && (wait_cnt_q == 8'(TIMEOUT_CYC - 1));
`else
   assign wait_to = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      job_d      = job_q;
      res_cand_d = res_cand_q;
      res_mode_d = res_mode_q;
      res_tag_d  = res_tag_q;
      res_err_d  = res_err_q;
      fifo_pop   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!fifo_empty) begin
               if (head.mode == MODE_ILL) begin
                  fifo_pop   = 1'b1;
                  res_cand_d = 8'd0;
                  res_mode_d = head.mode;
                  res_tag_d  = head.tag;
                  res_err_d  = 1'b1;
                  state_d    = StOut;
               end else if (!bus.set_busy) begin
                  fifo_pop = 1'b1;
                  job_d    = head;
                  state_d  = StIssue;
               end
            end
         end
         StIssue: state_d = StWait;
         StWait: begin
            if (bus.set_valid) begin
               res_cand_d = bus.set_candidate;
               res_mode_d = job_q.mode;
               res_tag_d  = job_q.tag;
               res_err_d  = 1'b0;
               state_d    = StOut;
            end else if (wait_to) begin
               res_cand_d = 8'd0;
               res_mode_d = job_q.mode;
               res_tag_d  = job_q.tag;
               res_err_d  = 1'b1;
               state_d    = StOut;
            end
         end
         StOut: begin
            if (bus.res_ready) state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdy_q      <= 1'b0;
         tag_q      <= 4'd0;
         state_q    <= StIdle;
         job_q      <= '0;
         res_cand_q <= 8'd0;
         res_mode_q <= 2'd0;
         res_tag_q  <= 4'd0;
         res_err_q  <= 1'b0;
      end else begin
         rdy_q      <= 1'b1;
         if (fifo_push) tag_q <= tag_q + 4'd1;
         state_q    <= state_d;
         job_q      <= job_d;
         res_cand_q <= res_cand_d;
         res_mode_q <= res_mode_d;
         res_tag_q  <= res_tag_d;
         res_err_q  <= res_err_d;
      end
   end

   assign bus.set_en        = (state_q == StIssue);
   assign bus.set_central   = bus.set_en ? job_q.central : 24'd0;
   assign bus.set_radius    = bus.set_en ? job_q.radius  : 12'd0;
   assign bus.set_mode      = bus.set_en ? job_q.mode    : 2'd0;

   assign bus.res_valid     = (state_q == StOut);
   assign bus.res_candidate = res_cand_q;
   assign bus.res_mode      = res_mode_q;
   assign bus.res_tag       = res_tag_q;
   assign bus.res_err       = res_err_q;

endmodule

// File: tb/tb_set_host.sv
// tb_set_host: directed and randomized bench for set_host with a behavioural
// SET lattice-count engine (16x16 grid, circle membership by squared distance).
module tb_set_host;
   import set_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   set_host_if bus ();

   set_host #(
      .CMD_DEPTH   (4),
      .TIMEOUT_CYC (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [7:0] cand;
      logic [1:0] mode;
      logic [3:0] tag;
      logic       err;
   } res_t;

   res_t       exp_q[$];
   res_t       got_q[$];
   logic [3:0] model_tag = 4'd0;
   int         n_cmp = 0;
   int         n_bad = 0;

   // Count grid points in circle A and/or B according to the mode rule
   function automatic logic [7:0] lattice(input logic [23:0] c, input logic [11:0] r,
                                          input logic [1:0] m);
      int ax, ay, bx, by, ra, rb, cnt;
      bit ina, inb, hit;
      ax  = int'(fld(c, CEN_AX_LSB));
      ay  = int'(fld(c, CEN_AY_LSB));
      bx  = int'(fld(c, CEN_BX_LSB));
      by  = int'(fld(c, CEN_BY_LSB));
      ra  = int'(fld({12'd0, r}, RAD_RA_LSB));
      rb  = int'(fld({12'd0, r}, RAD_RB_LSB));
      cnt = 0;
      for (int x = 0; x < 16; x++) begin
         for (int y = 0; y < 16; y++) begin
            ina = ((x - ax) * (x - ax) + (y - ay) * (y - ay)) <= ra * ra;
            inb = ((x - bx) * (x - bx) + (y - by) * (y - by)) <= rb * rb;
            case (m)
               2'd0:    hit = ina;
               2'd1:    hit = ina && inb;
               2'd2:    hit = ina != inb;
               default: hit = 1'b0;
            endcase
            if (hit) cnt++;
         end
      end
      return 8'(cnt);
   endfunction

   // Engine stand-in: random latency, optional long latency, optional silence
   logic       eng_busy, eng_valid;
   logic [7:0] eng_cand;
   int         eng_left;
   bit         eng_slow = 1'b0;
   bit         eng_dead = 1'b0;
   logic       spur_valid = 1'b0;
   logic [7:0] spur_cand = 8'd0;

   assign bus.set_busy      = eng_busy;
   assign bus.set_valid     = eng_valid | spur_valid;
   assign bus.set_candidate = spur_valid ? spur_cand : eng_cand;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         eng_busy  <= 1'b0;
         eng_valid <= 1'b0;
         eng_cand  <= 8'd0;
         eng_left  <= 0;
      end else begin
         eng_valid <= 1'b0;
         if (bus.set_en && !eng_dead) begin
            eng_busy <= 1'b1;
            eng_cand <= lattice(bus.set_central, bus.set_radius, bus.set_mode);
            eng_left <= eng_slow ? 40 : int'($urandom_range(6, 1));
         end else if (eng_busy) begin
            if (eng_left <= 1) begin
               eng_busy  <= 1'b0;
               eng_valid <= 1'b1;
            end else begin
               eng_left <= eng_left - 1;
            end
         end
      end
   end

   // Monitors: collect result transfers and watch engine-side rules
   int n_en = 0;
   int n_zero_viol = 0;
   int n_gap_viol = 0;
   int n_rv = 0;
   int cyc = 0;
   int last_sv = -100;

   always @(negedge clk) begin
      cyc++;
      if (!rst && bus.res_valid) n_rv++;
      if (!rst && bus.res_valid && bus.res_ready)
         got_q.push_back('{bus.res_candidate, bus.res_mode, bus.res_tag, bus.res_err});
      if (bus.set_en) begin
         n_en++;
         if (cyc - last_sv < 2) n_gap_viol++;
      end else if (bus.set_central != 24'd0 || bus.set_radius != 12'd0 || bus.set_mode != 2'd0) begin
         n_zero_viol++;
      end
      if (eng_valid) last_sv = cyc;
   end

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, expv);
      end
   endtask

   task automatic push_cmd(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m,
                           input bit to);
      res_t e;
      int   n;
      @(negedge clk);
      bus.cmd_valid   = 1'b1;
      bus.cmd_central = c;
      bus.cmd_radius  = r;
      bus.cmd_mode    = m;
      n = 0;
      while (!bus.cmd_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("push_accept", 32'(bus.cmd_ready), 32'd1);
      @(posedge clk);
      #1 bus.cmd_valid = 1'b0;
      e.err  = (m == MODE_ILL) || to;
      e.cand = e.err ? 8'd0 : lattice(c, r, m);
      e.mode = m;
      e.tag  = model_tag;
      exp_q.push_back(e);
      model_tag = model_tag + 4'd1;
   endtask

   task automatic wait_got(input int need);
      int n = 0;
      while (got_q.size() < need && n < 500) begin
         @(posedge clk);
         n++;
      end
   endtask

   task automatic check_one(input string name, input logic [7:0] cand, input logic [1:0] mode,
                            input logic [3:0] tag, input logic err);
      res_t g;
      wait_got(1);
      check({name, "_arrived"}, 32'(got_q.size() != 0), 32'd1);
      if (got_q.size() != 0) begin
         g = got_q.pop_front();
         if (exp_q.size() != 0) void'(exp_q.pop_front());
         check({name, "_cand"}, 32'(g.cand), 32'(cand));
         check({name, "_mode"}, 32'(g.mode), 32'(mode));
         check({name, "_tag"},  32'(g.tag),  32'(tag));
         check({name, "_err"},  32'(g.err),  32'(err));
      end
   endtask

   task automatic check_model(input string name);
      res_t g, e;
      int   ne;
      ne = exp_q.size();
      wait_got(ne);
      check({name, "_count"}, 32'(got_q.size()), 32'(ne));
      while (got_q.size() != 0 && exp_q.size() != 0) begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         check({name, "_cand"}, 32'(g.cand), 32'(e.cand));
         check({name, "_mode"}, 32'(g.mode), 32'(e.mode));
         check({name, "_tag"},  32'(g.tag),  32'(e.tag));
         check({name, "_err"},  32'(g.err),  32'(e.err));
      end
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_set_en"},    32'(bus.set_en),        32'd0);
      check({name, "_res_valid"}, 32'(bus.res_valid),     32'd0);
      check({name, "_res_cand"},  32'(bus.res_candidate), 32'd0);
      check({name, "_res_mode"},  32'(bus.res_mode),      32'd0);
      check({name, "_res_tag"},   32'(bus.res_tag),       32'd0);
      check({name, "_res_err"},   32'(bus.res_err),       32'd0);
      check({name, "_cmd_ready"}, 32'(bus.cmd_ready),     32'd0);
   endtask

   task automatic release_reset(input string name);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check({name, "_ready_low_first"}, 32'(bus.cmd_ready), 32'd0);
      @(negedge clk);
      check({name, "_ready_rise"}, 32'(bus.cmd_ready), 32'd1);
   endtask

   task automatic wait_set_en(output int found);
      int n = 0;
      found = 0;
      while (!bus.set_en && n < 200) begin
         @(negedge clk);
         n++;
      end
      found = int'(bus.set_en);
   endtask

   initial begin
      int     en_before, rv_before, found, n;
      logic [23:0] rc;
      logic [11:0] rr;
      bus.cmd_valid   = 1'b0;
      bus.cmd_central = 24'd0;
      bus.cmd_radius  = 12'd0;
      bus.cmd_mode    = 2'd0;
      bus.res_ready   = 1'b1;

      // Reset values and cmd_ready rising one clock after release
      repeat (2) @(negedge clk);
      check_reset_outputs("rst0");
      release_reset("rst0");

      // Single A-only job
      push_cmd(24'h444400, 12'h220, MODE_A, 1'b0);
      check_one("modeA", 8'd13, MODE_A, 4'd0, 1'b0);

      // AND then XOR of identical circles, in order
      push_cmd(24'h444400, 12'h220, MODE_AND, 1'b0);
      push_cmd(24'h444400, 12'h220, MODE_XOR, 1'b0);
      check_one("modeAND", 8'd13, MODE_AND, 4'd1, 1'b0);
      check_one("modeXOR", 8'd0,  MODE_XOR, 4'd2, 1'b0);

      // Illegal mode never starts the engine
      en_before = n_en;
      push_cmd(24'h444400, 12'h220, MODE_ILL, 1'b0);
      check_one("modeILL", 8'd0, MODE_ILL, 4'd3, 1'b1);
      check("ill_no_set_en", 32'(n_en), 32'(en_before));

      // Stray set_valid while idle and while a result is pending
      @(posedge clk);
      #1 spur_cand = 8'h55; spur_valid = 1'b1;
      @(posedge clk);
      #1 spur_valid = 1'b0;
      repeat (10) @(negedge clk);
      check("spur_idle_nores", 32'(got_q.size()), 32'd0);
      check("spur_idle_rv", 32'(bus.res_valid), 32'd0);
      @(posedge clk);
      #1 bus.res_ready = 1'b0;
      push_cmd(24'h444400, 12'h220, MODE_A, 1'b0);
      n = 0;
      while (!bus.res_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("spur_out_rv", 32'(bus.res_valid), 32'd1);
      @(posedge clk);
      #1 spur_cand = 8'h77; spur_valid = 1'b1;
      @(posedge clk);
      #1 spur_valid = 1'b0;
      @(negedge clk);
      check("spur_out_hold", 32'(bus.res_candidate), 32'd13);
      @(posedge clk);
      #1 bus.res_ready = 1'b1;
      check_one("spur_out", 8'd13, MODE_A, 4'd4, 1'b0);

      // Reset while the engine is working: job discarded, nothing emitted
      eng_slow = 1'b1;
      push_cmd(24'h444400, 12'h220, MODE_A, 1'b0);
      wait_set_en(found);
      check("rstwait_set_en", 32'(found), 32'd1);
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      #1 check_reset_outputs("rstwait");
      eng_slow  = 1'b0;
      exp_q.delete();
      model_tag = 4'd0;
      repeat (2) @(negedge clk);
      rv_before = n_rv;
      release_reset("rstwait");
      repeat (30) @(negedge clk);
      check("rstwait_no_res", 32'(got_q.size()), 32'd0);
      check("rstwait_no_rv", 32'(n_rv), 32'(rv_before));

      // Back-pressure: five commands, FIFO fills, nothing lost, tags 0..4
      @(posedge clk);
      #1 bus.res_ready = 1'b0;
      for (int i = 0; i < 5; i++) push_cmd(24'h444400, 12'h220, 2'(i % 3), 1'b0);
      @(negedge clk);
      check("full_ready_low", 32'(bus.cmd_ready), 32'd0);
      @(posedge clk);
      #1 bus.res_ready = 1'b1;
      check_one("bp0", 8'd13, MODE_A,   4'd0, 1'b0);
      check_one("bp1", 8'd13, MODE_AND, 4'd1, 1'b0);
      check_one("bp2", 8'd0,  MODE_XOR, 4'd2, 1'b0);
      check_one("bp3", 8'd13, MODE_A,   4'd3, 1'b0);
      check_one("bp4", 8'd13, MODE_AND, 4'd4, 1'b0);

      // Random commands against the model (covers tag wrap past 15)
      for (int i = 0; i < 24; i++) begin
         rc = 24'($urandom);
         rr = 12'($urandom);
         push_cmd(rc, rr, 2'($urandom_range(3, 0)), 1'b0);
      end
      check_model("rand");

      check("set_fields_zero", 32'(n_zero_viol), 32'd0);
      check("valid_to_en_gap", 32'(n_gap_viol), 32'd0);

`ifdef SET_HOST_TIMEOUT_EN
      // Silent engine: watchdog aborts after 16 WAIT cycles
      eng_dead = 1'b1;
      push_cmd(24'h444400, 12'h220, MODE_A, 1'b1);
      wait_set_en(found);
      check("to_set_en", 32'(found), 32'd1);
      n = 0;
      while (!bus.res_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("to_latency", 32'(n), 32'd17);
      check_one("to", 8'd0, MODE_A, model_tag - 4'd1, 1'b1);
      @(posedge clk);
      #1 spur_cand = 8'h33; spur_valid = 1'b1;
      @(posedge clk);
      #1 spur_valid = 1'b0;
      repeat (10) @(negedge clk);
      check("to_late_ignored", 32'(got_q.size()), 32'd0);
      eng_dead = 1'b0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
